// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - user LED pattern generator (off/blink/chase/breathe), breathe gated by LED_PATTERN_BREATHE_EN
module led_pattern_gen #(
    parameter int STEP_CYC = 25_000_000,
    parameter int LED_NUM  = 2,
    parameter int PWM_BITS = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         mode,
    input  logic               pause,
    output logic [LED_NUM-1:0] led,
    output logic               step_tick,
    output logic [1:0]         cur_mode
);

    localparam int PW = $clog2(STEP_CYC);
    localparam logic [PW-1:0] PCNT_MAX = PW'(STEP_CYC - 1);

    // Reject parameter values the pattern logic cannot represent.
    if (STEP_CYC < 2) begin : g_bad_step
        $error("STEP_CYC must be >= 2");
    end
    if (LED_NUM < 1) begin : g_bad_led
        $error("LED_NUM must be >= 1");
    end
    if (PWM_BITS < 2) begin : g_bad_pwm
        $error("PWM_BITS must be >= 2");
    end

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_BLINK   = 2'd1,
        S_CHASE   = 2'd2,
        S_BREATHE = 2'd3
    } state_t;

    logic [PW-1:0]      pcnt_q;
    logic [1:0]         mode_q;
    state_t             state_q, state_d, tgt;
    logic [LED_NUM-1:0] led_q, led_d, led_rot;

`ifdef LED_PATTERN_BREATHE_EN
    localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_TOP_1 = PWM_MAX - 1'b1;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_up_q, dir_up_d;
`endif

    assign step_tick = (pcnt_q == PCNT_MAX) && !pause;
    assign led       = led_q;
    assign cur_mode  = state_q;
    // Rotate-left that degenerates to identity when only one LED exists.
    assign led_rot   = (led_q << 1) | (led_q >> (LED_NUM - 1));

    // Requested mode as displayed; without breathe support mode 3 falls back to blink.
`ifdef LED_PATTERN_BREATHE_EN
    assign tgt = state_t'(mode_q);
`else
    assign tgt = (mode_q == 2'd3) ? S_BLINK : state_t'(mode_q);
`endif

    // Step prescaler, frozen while paused.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcnt_q <= '0;
        end else if (!pause) begin
            pcnt_q <= (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + 1'b1;
        end
    end

    // Mode request is sampled every cycle, even while paused.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= 2'd0;
        end else begin
            mode_q <= mode;
        end
    end

    // Pattern state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_OFF;
            led_q     <= '0;
`ifdef LED_PATTERN_BREATHE_EN
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            dir_up_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
`ifdef LED_PATTERN_BREATHE_EN
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            dir_up_q  <= dir_up_d;
`endif
        end
    end

    // Mode switch on ticks takes priority over the step action; breathe runs every unpaused cycle.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
`ifdef LED_PATTERN_BREATHE_EN
        pwm_cnt_d = pwm_cnt_q;
        duty_d    = duty_q;
        dir_up_d  = dir_up_q;
`endif
        if (step_tick && (tgt != state_q)) begin
            state_d = tgt;
            case (tgt)
                S_OFF:   led_d = '0;
                S_BLINK: led_d = '1;
                S_CHASE: led_d = LED_NUM'(1);
                default: begin
                    led_d = '0;
`ifdef LED_PATTERN_BREATHE_EN
                    pwm_cnt_d = '0;
                    duty_d    = '0;
                    dir_up_d  = 1'b1;
`endif
                end
            endcase
        end else if (!pause) begin
            case (state_q)
                S_OFF:   led_d = '0;
                S_BLINK: if (step_tick) led_d = ~led_q;
                S_CHASE: if (step_tick) led_d = led_rot;
                default: begin
`ifdef LED_PATTERN_BREATHE_EN
                    pwm_cnt_d = pwm_cnt_q + 1'b1;
                    led_d     = {LED_NUM{pwm_cnt_q < duty_q}};
                    if (pwm_cnt_q == PWM_MAX) begin
                        if (dir_up_q) begin
                            duty_d = duty_q + 1'b1;
                            if (duty_q == DUTY_TOP_1) dir_up_d = 1'b0;
                        end else begin
                            duty_d = duty_q - 1'b1;
                            if (duty_q == PWM_BITS'(1)) dir_up_d = 1'b1;
                        end
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED driver for the board's user LEDs. Generates one of four runtime-selectable patterns on `LED_NUM` outputs: off, blink, chase and breathe. Pattern timing comes from an internal prescaler running off the system clock. It sits directly behind the top-level LED pins and replaces the fixed two-LED 1 s blinker.

## Interface
- `STEP_CYC`, default 25_000_000: `sys_clk` cycles per pattern step (0.5 s at 50 MHz); legal range ≥ 2.
- `LED_NUM`, default 2: number of LED outputs; legal range ≥ 1.
- `PWM_BITS`, default 8: PWM counter and duty width for breathe; legal range ≥ 2.
- `sys_clk`, in, 1: system clock.
- `sys_rst_n`, in, 1: asynchronous, active-low reset.
- `mode`, in, 2: requested pattern; 0 = OFF, 1 = BLINK, 2 = CHASE, 3 = BREATHE.
- `pause`, in, 1: high freezes the prescaler and all pattern state; outputs hold.
- `led`, out, `LED_NUM`: LED drive, registered, active-high.
- `step_tick`, out, 1: one-cycle pulse on the last cycle of each step period.
- `cur_mode`, out, 2: mode currently being displayed.

## Operation
- Prescaler `pcnt`, width `$clog2(STEP_CYC)`:
  - Increments every cycle while `pause`=0.
  - Wraps to 0 at `STEP_CYC-1`.
  - `step_tick` = 1 exactly when `pcnt`==`STEP_CYC-1` and `pause`=0. It is combinational from `pcnt`/`pause`, so no register stage.
- Mode FSM states, with `cur_mode` encoded as in the `mode` port:
  - S_OFF (0)
  - S_BLINK (1)
  - S_CHASE (2)
  - S_BREATHE (3)
- Mode change:
  - `mode` is registered every cycle into `mode_q`.
  - On a `step_tick` with `mode_q`≠`cur_mode`, the FSM moves to `mode_q` and initialises the new pattern. This replaces the normal step action on that tick.
  - Mode changes only take effect on ticks, never mid-step.
- Initialisation on entry:
  - OFF: `led`=0.
  - BLINK: `led`=all ones.
  - CHASE: `led`=`{0..0,1}` (bit 0).
  - BREATHE: `duty`=0, direction = up, `pwm_cnt`=0, `led`=0.
- Step action on each `step_tick` with no mode change:
  - OFF: hold 0.
  - BLINK: `led` <= ~`led`, all bits together.
  - CHASE: rotate left by 1 (`led[LED_NUM-1]` wraps to bit 0). With `LED_NUM`=1 the output stays 1.
  - BREATHE: no step action.
- Breathe engine, active only in S_BREATHE and not paused:
  - `pwm_cnt` (`PWM_BITS` wide) increments every cycle and wraps naturally.
  - `led` <= all bits = (`pwm_cnt` < `duty`), registered.
  - When `pwm_cnt` wraps to 0, `duty` moves one step in the current direction. Direction reverses on reaching max (2^`PWM_BITS`-1) or 0.
  - Full breathe period = 2·(2^`PWM_BITS`-1)·2^`PWM_BITS` cycles, independent of `STEP_CYC`.
- `pause`: all registers except `mode_q` hold. A mode change requested during pause is applied on the first tick after release.

## Timing
- Reset values: `led`=0, `step_tick`=0, `cur_mode`=0 (S_OFF), `pcnt`=0, `mode_q`=0, `duty`=0, `pwm_cnt`=0, direction = up.
- The first `step_tick` after reset release occurs on cycle `STEP_CYC-1`, counting the first clock edge after release as cycle 0.
- Mode latency: a `mode` change is sampled into `mode_q` 1 cycle later. `led` and `cur_mode` then update on the clock edge ending the next tick cycle, so the worst case is `STEP_CYC`+1 cycles.
- Step updates: `led` changes on the edge that ends the tick cycle, so `led` is stable for exactly `STEP_CYC` cycles per step in BLINK and CHASE.
- `pause` asserted on a tick cycle suppresses that tick entirely; it is not deferred.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The pattern restarts from S_OFF.
- Boundary at max `duty`: the PWM output is high for 2^`PWM_BITS`-1 of 2^`PWM_BITS` cycles. It is never fully on.

## Configuration
- `LED_PATTERN_BREATHE_EN`:
  - Defined: the breathe engine and S_BREATHE are compiled in as described above.
  - Undefined: `pwm_cnt`, `duty` and the direction logic are removed. `mode`=3 is treated as BLINK, so `cur_mode` reports 1 and the blink behaviour applies.

## Test plan
- Reset, with `STEP_CYC`=4, `LED_NUM`=4, `mode`=1 held: `led`=0000 until the first tick (cycle 3). The first tick enters BLINK with `led`=1111, then `led` toggles every 4 cycles (1111, 0000, 1111) and `cur_mode`=1.
- CHASE, `mode`=2 from reset: after the entry tick `led`=0001, then 0010, 0100, 1000, 0001 on successive ticks (wrap). `step_tick` pulses exactly once per 4 cycles.
- Mode change mid-step: in BLINK, change `mode` to 2 one cycle after a tick. `led` is unchanged until the next tick, then equals 0001 and `cur_mode`=2.
- Pause: assert `pause` for 10 cycles in CHASE with `led`=0100. `led`, `pcnt` and `step_tick` stay frozen (`step_tick`=0). After release the next tick occurs exactly the remaining-step cycles later and `led`=1000.
- BREATHE with `PWM_BITS`=2, `LED_PATTERN_BREATHE_EN` defined:
  - `duty` sequence per 4-cycle PWM period is 0, 1, 2, 3, 2, 1, 0, 1, …
  - `led` high-cycle count per period matches `duty`.
  - With the macro undefined, `mode`=3 gives BLINK and `cur_mode`=1.
- Async reset asserted mid-BLINK with `led`=1111: `led`=0 and `cur_mode`=0 in the same cycle without a clock edge. After release the sequence matches the first scenario.
